// File: rtl/vram_arb_if.sv
// -----------------------------------------------------------------------------
// vram_arb_if
//
// Bundles every signal exchanged between the VRAM arbiter and its environment:
// the three requesters (video fetch, CPU register port, blitter/fill engine),
// the read-data return path, the registered VRAM port and the owner tag.
//
// Modports:
//   slave  - the arbiter: samples requests and ram_do, drives acks, rdata,
//            the ram_* port and cur_owner.
//   master - the environment: drives requests and ram_do, observes the rest.
//
// Signal summary:
//   vid_req/vid_addr/vid_ack                      video fetch (read-only)
//   cpu_req/cpu_we/cpu_addr/cpu_di/cpu_ack        CPU register port
//   blt_req/blt_we/blt_addr/blt_di/blt_ack        blitter / fill engine
//   rdata                                         read data, valid with an ack
//   ram_en/ram_we/ram_addr/ram_di                 registered VRAM access
//   ram_do                                        VRAM read data
//   cur_owner                                     0 none, 1 vid, 2 cpu, 3 blt
// -----------------------------------------------------------------------------
interface vram_arb_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_ack;

    logic              blt_req;
    logic              blt_we;
    logic [ADDR_W-1:0] blt_addr;
    logic [DATA_W-1:0] blt_di;
    logic              blt_ack;

    logic [DATA_W-1:0] rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;

    logic [1:0]        cur_owner;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_di,
        input  blt_req, blt_we, blt_addr, blt_di,
        input  ram_do,
        output vid_ack, cpu_ack, blt_ack,
        output rdata,
        output ram_en, ram_we, ram_addr, ram_di,
        output cur_owner
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_di,
        output blt_req, blt_we, blt_addr, blt_di,
        output ram_do,
        input  vid_ack, cpu_ack, blt_ack,
        input  rdata,
        input  ram_en, ram_we, ram_addr, ram_di,
        input  cur_owner
    );
endinterface

// File: rtl/vram_arb.sv
// -----------------------------------------------------------------------------
// vram_arb
//
// Three-way arbiter in front of a synchronous single-port VRAM. At every
// rising clock edge one requester may be granted; its access is registered
// onto the ram_* port at that edge, the VRAM samples it at the next edge, and
// the winner's ack is high for the cycle after that, with rdata wired straight
// from ram_do. A grant can be issued at every edge, so the VRAM can be busy
// on every cycle.
//
// Arbitration order at each edge:
//   1. a starved CPU or blitter (wait counter at STARVE_MAX)
//   2. video fetch
//   3. CPU / blitter, round-robin between the two
// A requester that won at the previous edge is still holding its request
// (it only learns of the grant when its ack arrives) and is skipped, so no
// request is ever granted twice.
//
// Parameters:
//   ADDR_W      VRAM address width
//   DATA_W      data width
//   STARVE_MAX  wait-cycle limit for CPU and blitter
//   VID_HOLDOFF when cleared, video stays eligible right after its own grant;
//               only meant for directed starvation testing, keep at 1
//
// Ports:
//   clk  single clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  vram_arb_if slave modport (requesters, VRAM port, rdata, cur_owner)
// -----------------------------------------------------------------------------
module vram_arb #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int STARVE_MAX  = 8,
    parameter bit VID_HOLDOFF = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    vram_arb_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_BLT  = 2'd3
    } owner_e;

    localparam int                WAIT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

    // owner_q is the access currently presented on ram_*; it doubles as the
    // "granted at the previous edge" marker and as the in-flight tag that
    // turns into an ack one edge later.
    owner_e            owner_q,    owner_d;
    logic              ram_en_q,   ram_en_d;
    logic              ram_we_q,   ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_di_q,   ram_di_d;
    logic              vid_ack_q,  vid_ack_d;
    logic              cpu_ack_q,  cpu_ack_d;
    logic              blt_ack_q,  blt_ack_d;
    // Round-robin pointer: 0 favours the CPU, 1 favours the blitter.
    logic              rr_blt_q,   rr_blt_d;
    logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
    logic [WAIT_W-1:0] blt_wait_q, blt_wait_d;

    logic   vid_elig;
    logic   cpu_elig;
    logic   blt_elig;
    logic   cpu_starved;
    logic   blt_starved;
    owner_e winner;

    // Decide who wins the current edge. Eligibility removes whoever was
    // granted at the previous edge; the round-robin pointer only arbitrates
    // between CPU and blitter, both in the starved tier and the normal tier.
    always_comb begin
        vid_elig    = bus.vid_req && !(VID_HOLDOFF && (owner_q == OWN_VID));
        cpu_elig    = bus.cpu_req && (owner_q != OWN_CPU);
        blt_elig    = bus.blt_req && (owner_q != OWN_BLT);
        cpu_starved = cpu_elig && (cpu_wait_q == WAIT_MAX);
        blt_starved = blt_elig && (blt_wait_q == WAIT_MAX);
        winner      = OWN_NONE;

        if (cpu_starved || blt_starved) begin
            winner = (cpu_starved && (!blt_starved || !rr_blt_q)) ? OWN_CPU : OWN_BLT;
        end else if (vid_elig) begin
            winner = OWN_VID;
        end else if (cpu_elig || blt_elig) begin
            winner = (cpu_elig && (!blt_elig || !rr_blt_q)) ? OWN_CPU : OWN_BLT;
        end
    end

    // Next-state for the VRAM port, acks, round-robin pointer and wait
    // counters. With no winner the address and write data simply hold, so the
    // VRAM pins do not toggle on idle cycles; the write enable is forced low.
    always_comb begin
        owner_d    = winner;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        rr_blt_d   = rr_blt_q;
        cpu_wait_d = cpu_wait_q;
        blt_wait_d = blt_wait_q;

        case (winner)
            OWN_VID: begin
                ram_en_d   = 1'b1;
                ram_addr_d = bus.vid_addr;
                ram_di_d   = '0;
            end
            OWN_CPU: begin
                ram_en_d   = 1'b1;
                ram_we_d   = bus.cpu_we;
                ram_addr_d = bus.cpu_addr;
                ram_di_d   = bus.cpu_di;
                rr_blt_d   = 1'b1;
            end
            OWN_BLT: begin
                ram_en_d   = 1'b1;
                ram_we_d   = bus.blt_we;
                ram_addr_d = bus.blt_addr;
                ram_di_d   = bus.blt_di;
                rr_blt_d   = 1'b0;
            end
            default: begin
                ram_en_d = 1'b0;
            end
        endcase

        // The access registered at the previous edge is sampled by the VRAM
        // at this edge, so its owner's ack rises now.
        vid_ack_d = (owner_q == OWN_VID);
        cpu_ack_d = (owner_q == OWN_CPU);
        blt_ack_d = (owner_q == OWN_BLT);

        if (!bus.cpu_req || (winner == OWN_CPU)) begin
            cpu_wait_d = '0;
        end else if (cpu_wait_q != WAIT_MAX) begin
            cpu_wait_d = cpu_wait_q + WAIT_W'(1);
        end

        if (!bus.blt_req || (winner == OWN_BLT)) begin
            blt_wait_d = '0;
        end else if (blt_wait_q != WAIT_MAX) begin
            blt_wait_d = blt_wait_q + WAIT_W'(1);
        end
    end

    // State register. Reset drops any in-flight access without an ack; the
    // requester keeps its request up and is served again after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            blt_ack_q  <= 1'b0;
            rr_blt_q   <= 1'b0;
            cpu_wait_q <= '0;
            blt_wait_q <= '0;
        end else begin
            owner_q    <= owner_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            vid_ack_q  <= vid_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            blt_ack_q  <= blt_ack_d;
            rr_blt_q   <= rr_blt_d;
            cpu_wait_q <= cpu_wait_d;
            blt_wait_q <= blt_wait_d;
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_di    = ram_di_q;
    assign bus.cur_owner = owner_q;
    assign bus.vid_ack   = vid_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.blt_ack   = blt_ack_q;
    // Only one ack is ever high, so a single shared return path suffices.
    assign bus.rdata     = bus.ram_do;

endmodule

// File: tb/tb_vram_arb.sv
// -----------------------------------------------------------------------------
// tb_vram_arb
//
// Drives the VRAM arbiter through directed scenarios (single CPU access,
// CPU/blitter ping-pong, video sharing, forced starvation on a second
// instance, reset during an in-flight access) followed by random traffic from
// all three requesters checked against a simple arbitration model and a
// reference memory.
// -----------------------------------------------------------------------------
module tb_vram_arb;
    localparam int ADDR_W       = 13;
    localparam int DATA_W       = 8;
    localparam int STARVE_MAX   = 8;
    localparam int RND_CYCLES   = 3000;
    localparam int DRAIN_CYCLES = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    vram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    vram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus4 ();

    vram_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Second instance with video allowed to win back-to-back, so CPU
    // starvation can actually be provoked.
    vram_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .VID_HOLDOFF(1'b0)
    ) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    // Synchronous single-port VRAM: samples the port at the edge, read data
    // appears one clock later.
    logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) vram[bus.ram_addr] <= bus.ram_di;
            bus.ram_do <= vram[bus.ram_addr];
        end
    end

    assign bus4.ram_do = '0;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    bit                rv, rc, rb, cw, bw;
    logic [ADDR_W-1:0] va, ca, ba;
    logic [DATA_W-1:0] cd, bd;

    // Arbitration model state (plain integers: 0 none, 1 vid, 2 cpu, 3 blt).
    int last_owner, cpu_wait, blt_wait, prev_pred;
    bit favour_blt;
    int grant_total, ack_total;

    logic [DATA_W-1:0] ref_mem   [0:15];
    bit                ref_valid [0:15];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.vid_req  = rv;  bus.vid_addr = va;
        bus.cpu_req  = rc;  bus.cpu_we   = cw;  bus.cpu_addr = ca;  bus.cpu_di = cd;
        bus.blt_req  = rb;  bus.blt_we   = bw;  bus.blt_addr = ba;  bus.blt_di = bd;
    endtask

    task automatic idleAll();
        rv = 0; rc = 0; rb = 0; cw = 0; bw = 0;
        va = '0; ca = '0; ba = '0; cd = '0; bd = '0;
        applyStimulus();
        bus4.vid_req = 0; bus4.vid_addr = '0;
        bus4.cpu_req = 0; bus4.cpu_we = 0; bus4.cpu_addr = '0; bus4.cpu_di = '0;
        bus4.blt_req = 0; bus4.blt_we = 0; bus4.blt_addr = '0; bus4.blt_di = '0;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idleAll();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] randAddr();
        return ADDR_W'(13'h0200 | 13'($urandom_range(0, 15)));
    endfunction

    // Who should win the coming edge, from the arbitration rules.
    function automatic int predictOwner();
        bit ve, ce, be, cs, bs;
        ve = rv && (last_owner != 1);
        ce = rc && (last_owner != 2);
        be = rb && (last_owner != 3);
        cs = ce && (cpu_wait == STARVE_MAX);
        bs = be && (blt_wait == STARVE_MAX);
        if (cs && bs) return favour_blt ? 3 : 2;
        if (cs) return 2;
        if (bs) return 3;
        if (ve) return 1;
        if (ce && be) return favour_blt ? 3 : 2;
        if (ce) return 2;
        if (be) return 3;
        return 0;
    endfunction

    task automatic updateModel(input int g);
        if (g == 2 || !rc) cpu_wait = 0;
        else if (cpu_wait < STARVE_MAX) cpu_wait++;
        if (g == 3 || !rb) blt_wait = 0;
        else if (blt_wait < STARVE_MAX) blt_wait++;
        if (g == 2) favour_blt = 1;
        if (g == 3) favour_blt = 0;
        last_owner = g;
    endtask

    initial begin
        int exp_owner;
        int prev_owner;

        idleAll();
        #1 rst = 1'b1;
        #11;
        $display("[TB] reset state");
        checkOutput("rst_ram_en",   32'(bus.ram_en),    0);
        checkOutput("rst_owner",    32'(bus.cur_owner), 0);
        checkOutput("rst_ram_addr", 32'(bus.ram_addr),  0);
        checkOutput("rst_acks",     32'({bus.vid_ack, bus.cpu_ack, bus.blt_ack}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single CPU write then read of 0x0123; no regrant while ack pending.
        $display("[TB] single CPU access");
        rc = 1; cw = 1; ca = 13'h0123; cd = 8'hA5; applyStimulus();
        waitEdge();
        checkOutput("cpuw_owner", 32'(bus.cur_owner), 2);
        checkOutput("cpuw_en",    32'(bus.ram_en),    1);
        checkOutput("cpuw_we",    32'(bus.ram_we),    1);
        checkOutput("cpuw_addr",  32'(bus.ram_addr),  32'h0123);
        checkOutput("cpuw_di",    32'(bus.ram_di),    32'hA5);
        waitEdge();
        checkOutput("cpuw_ack",   32'(bus.cpu_ack),   1);
        checkOutput("cpuw_noreg", 32'(bus.ram_en),    0);
        rc = 0; cw = 0; cd = 8'h00; applyStimulus();
        waitEdge();
        checkOutput("cpuw_ackoff", 32'(bus.cpu_ack),  0);
        rc = 1; applyStimulus();
        waitEdge();
        checkOutput("cpur_en",    32'(bus.ram_en),    1);
        checkOutput("cpur_we",    32'(bus.ram_we),    0);
        checkOutput("cpur_addr",  32'(bus.ram_addr),  32'h0123);
        waitEdge();
        checkOutput("cpur_ack",   32'(bus.cpu_ack),   1);
        checkOutput("cpur_rdata", 32'(bus.rdata),     32'hA5);
        checkOutput("cpur_noreg", 32'(bus.ram_en),    0);
        checkOutput("cpur_owner", 32'(bus.cur_owner), 0);
        rc = 0; applyStimulus();
        waitEdge();
        checkOutput("cpur_ackoff", 32'(bus.cpu_ack),  0);
        checkOutput("idle_hold",   32'(bus.ram_addr), 32'h0123);
        checkOutput("idle_we",     32'(bus.ram_we),   0);

        // CPU and blitter writing continuously: strict alternation.
        $display("[TB] CPU/blitter ping-pong");
        doReset();
        rc = 1; cw = 1; ca = 13'h0300; cd = 8'h10;
        rb = 1; bw = 1; ba = 13'h0400; bd = 8'h20;
        applyStimulus();
        prev_owner = 0;
        for (int k = 0; k < 8; k++) begin
            exp_owner = (k % 2 == 0) ? 2 : 3;
            waitEdge();
            checkOutput("pp_owner", 32'(bus.cur_owner), 32'(exp_owner));
            checkOutput("pp_en",    32'(bus.ram_en),    1);
            checkOutput("pp_addr",  32'(bus.ram_addr),  32'(exp_owner == 2 ? ca : ba));
            checkOutput("pp_cack",  32'(bus.cpu_ack),   32'(prev_owner == 2));
            checkOutput("pp_back",  32'(bus.blt_ack),   32'(prev_owner == 3));
            if (prev_owner == 2) begin ca = ca + 13'd1; cd = cd + 8'd1; end
            if (prev_owner == 3) begin ba = ba + 13'd1; bd = bd + 8'd1; end
            applyStimulus();
            prev_owner = exp_owner;
        end

        // Video held with CPU reading: video every other cycle, CPU in gaps.
        $display("[TB] video sharing with CPU");
        doReset();
        rv = 1; va = 13'h0123;
        rc = 1; cw = 0; ca = 13'h0123;
        applyStimulus();
        prev_owner = 0;
        for (int k = 0; k < 10; k++) begin
            exp_owner = (k % 2 == 0) ? 1 : 2;
            waitEdge();
            checkOutput("vs_owner", 32'(bus.cur_owner), 32'(exp_owner));
            checkOutput("vs_en",    32'(bus.ram_en),    1);
            checkOutput("vs_vack",  32'(bus.vid_ack),   32'(prev_owner == 1));
            checkOutput("vs_cack",  32'(bus.cpu_ack),   32'(prev_owner == 2));
            if (prev_owner != 0) checkOutput("vs_rdata", 32'(bus.rdata), 32'hA5);
            prev_owner = exp_owner;
        end
        idleAll();

        // Starvation: video wins back-to-back, CPU breaks through every 5th.
        $display("[TB] forced starvation");
        doReset();
        bus4.vid_req = 1; bus4.vid_addr = 13'h0040;
        bus4.cpu_req = 1; bus4.cpu_we = 0; bus4.cpu_addr = 13'h0041;
        prev_owner = 0;
        for (int k = 0; k < 10; k++) begin
            exp_owner = (k == 4 || k == 9) ? 2 : 1;
            waitEdge();
            checkOutput("st_owner", 32'(bus4.cur_owner), 32'(exp_owner));
            checkOutput("st_en",    32'(bus4.ram_en),    1);
            checkOutput("st_we",    32'(bus4.ram_we),    0);
            checkOutput("st_addr",  32'(bus4.ram_addr),  32'(exp_owner == 2 ? 13'h0041 : 13'h0040));
            checkOutput("st_cack",  32'(bus4.cpu_ack),   32'(prev_owner == 2));
            checkOutput("st_vack",  32'(bus4.vid_ack),   32'(prev_owner == 1));
            checkOutput("st_back",  32'(bus4.blt_ack),   0);
            checkOutput("st_rdata", 32'(bus4.rdata),     0);
            checkOutput("st_di",    32'(bus4.ram_di),    0);
            prev_owner = exp_owner;
        end
        idleAll();

        // Reset while a blitter write is in flight: no ack, re-served after.
        $display("[TB] reset during blitter access");
        doReset();
        rb = 1; bw = 1; ba = 13'h0456; bd = 8'h3C; applyStimulus();
        waitEdge();
        checkOutput("rb_owner", 32'(bus.cur_owner), 3);
        rst = 1'b1;
        #1;
        checkOutput("rb_en",    32'(bus.ram_en),    0);
        checkOutput("rb_we",    32'(bus.ram_we),    0);
        checkOutput("rb_addr",  32'(bus.ram_addr),  0);
        checkOutput("rb_di",    32'(bus.ram_di),    0);
        checkOutput("rb_own0",  32'(bus.cur_owner), 0);
        waitEdge();
        checkOutput("rb_noack", 32'(bus.blt_ack),   0);
        @(negedge clk);
        rst = 1'b0;
        waitEdge();
        checkOutput("rb_regrant", 32'(bus.cur_owner), 3);
        checkOutput("rb_readdr",  32'(bus.ram_addr),  32'h0456);
        checkOutput("rb_redi",    32'(bus.ram_di),    32'h3C);
        waitEdge();
        checkOutput("rb_ack",     32'(bus.blt_ack),   1);
        rb = 0; applyStimulus();
        waitEdge();
        checkOutput("rb_ackoff",  32'(bus.blt_ack),   0);
        rb = 1; bw = 0; applyStimulus();
        waitEdge();
        waitEdge();
        checkOutput("rb_rdack",   32'(bus.blt_ack),   1);
        checkOutput("rb_rdata",   32'(bus.rdata),     32'h3C);
        idleAll();

        // Random three-requester traffic.
        $display("[TB] random traffic");
        doReset();
        last_owner = 0; cpu_wait = 0; blt_wait = 0; favour_blt = 0; prev_pred = 0;
        grant_total = 0; ack_total = 0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        for (int cyc = 0; cyc < RND_CYCLES + DRAIN_CYCLES; cyc++) begin
            int pred;
            int acks_seen;
            bit draining;
            draining = (cyc >= RND_CYCLES);
            pred = predictOwner();
            waitEdge();
            updateModel(pred);
            if (pred != 0) grant_total++;
            checkOutput("rnd_owner", 32'(bus.cur_owner), 32'(pred));
            checkOutput("rnd_en",    32'(bus.ram_en),    32'(pred != 0));
            if (pred == 1) begin
                checkOutput("rnd_vaddr", 32'(bus.ram_addr), 32'(va));
                checkOutput("rnd_vwe",   32'(bus.ram_we),   0);
                checkOutput("rnd_vdi",   32'(bus.ram_di),   0);
            end else if (pred == 2) begin
                checkOutput("rnd_caddr", 32'(bus.ram_addr), 32'(ca));
                checkOutput("rnd_cwe",   32'(bus.ram_we),   32'(cw));
                if (cw) checkOutput("rnd_cdi", 32'(bus.ram_di), 32'(cd));
            end else if (pred == 3) begin
                checkOutput("rnd_baddr", 32'(bus.ram_addr), 32'(ba));
                checkOutput("rnd_bwe",   32'(bus.ram_we),   32'(bw));
                if (bw) checkOutput("rnd_bdi", 32'(bus.ram_di), 32'(bd));
            end else begin
                checkOutput("rnd_idlewe", 32'(bus.ram_we), 0);
            end
            acks_seen = int'(bus.vid_ack) + int'(bus.cpu_ack) + int'(bus.blt_ack);
            ack_total += acks_seen;
            checkOutput("rnd_oneack", 32'(acks_seen <= 1), 1);
            checkOutput("rnd_vack", 32'(bus.vid_ack), 32'(prev_pred == 1));
            checkOutput("rnd_cack", 32'(bus.cpu_ack), 32'(prev_pred == 2));
            checkOutput("rnd_back", 32'(bus.blt_ack), 32'(prev_pred == 3));

            if (prev_pred == 1) begin
                if (ref_valid[va[3:0]])
                    checkOutput("rnd_vrdata", 32'(bus.rdata), 32'(ref_mem[va[3:0]]));
                if (draining || $urandom_range(0, 1) == 0) rv = 0;
                else va = randAddr();
            end else if (prev_pred == 2) begin
                if (cw) begin
                    ref_mem[ca[3:0]] = cd;
                    ref_valid[ca[3:0]] = 1'b1;
                end else if (ref_valid[ca[3:0]]) begin
                    checkOutput("rnd_crdata", 32'(bus.rdata), 32'(ref_mem[ca[3:0]]));
                end
                if (draining || $urandom_range(0, 1) == 0) rc = 0;
                else begin ca = randAddr(); cw = 1'($urandom); cd = 8'($urandom); end
            end else if (prev_pred == 3) begin
                if (bw) begin
                    ref_mem[ba[3:0]] = bd;
                    ref_valid[ba[3:0]] = 1'b1;
                end else if (ref_valid[ba[3:0]]) begin
                    checkOutput("rnd_brdata", 32'(bus.rdata), 32'(ref_mem[ba[3:0]]));
                end
                if (draining || $urandom_range(0, 1) == 0) rb = 0;
                else begin ba = randAddr(); bw = 1'($urandom); bd = 8'($urandom); end
            end

            if (!draining) begin
                if (!rv && $urandom_range(0, 2) != 0) begin
                    rv = 1; va = randAddr();
                end
                if (!rc && $urandom_range(0, 2) != 0) begin
                    rc = 1; ca = randAddr(); cw = 1'($urandom); cd = 8'($urandom);
                end
                if (!rb && $urandom_range(0, 2) != 0) begin
                    rb = 1; ba = randAddr(); bw = 1'($urandom); bd = 8'($urandom);
                end
            end
            prev_pred = pred;
            applyStimulus();
        end
        checkOutput("rnd_drained",  32'({rv, rc, rb}), 0);
        checkOutput("rnd_ackcount", 32'(ack_total),    32'(grant_total));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, VRAM address width; DATA_W, default 8, data width; STARVE_MAX, default 8, wait-cycle limit for CPU/blitter.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 vid_req  in  1  / vid_addr  in  ADDR_W  / vid_ack  out  1: video fetch requester, read-only.
REQ-005 cpu_req  in  1  / cpu_we  in  1  / cpu_addr  in  ADDR_W  / cpu_di  in  DATA_W  / cpu_ack  out  1: CPU register-port requester.
REQ-006 blt_req  in  1  / blt_we  in  1  / blt_addr  in  ADDR_W  / blt_di  in  DATA_W  / blt_ack  out  1: blitter/fill requester.
REQ-007 rdata  out  DATA_W: read data, wired from ram_do, valid only while an ack is high.
REQ-008 ram_en  out  1 / ram_we  out  1 / ram_addr  out  ADDR_W / ram_di  out  DATA_W: registered port to synchronous single-port VRAM clocked by clk.
REQ-009 ram_do  in  DATA_W: VRAM read data, valid one clk after the access is sampled.
REQ-010 cur_owner  out  2: id of the access presented on ram_* (0 none, 1 vid, 2 cpu, 3 blt).

Function
REQ-011 Handshake: requester holds req and its address, we and di stable until its ack; ack is a one-cycle pulse; requester drops or renews req in the ack cycle.
REQ-012 Timing: arbitration uses inputs sampled at edge E1; winner's access registered onto ram_* at E1; VRAM samples at E2; winner's ack high from E2 to E3, with rdata = ram_do.
REQ-013 Reads and writes SHALL have identical ack timing; vid_we is implicitly 0.
REQ-014 A requester granted at the previous edge SHALL be ineligible at the current edge, so each requester gets at most one grant per 2 cycles and no duplicate grant.
REQ-015 Pipelining: a grant SHALL be issuable at every edge to a different requester; the VRAM may be busy on every cycle.
REQ-016 Priority: a starved requester first (see REQ-018), then vid, then CPU/blt round-robin.
REQ-017 Round-robin: when CPU and blt both compete, the one not granted last among the two wins; pointer updates only on CPU or blt grants; pointer after reset favours CPU.
REQ-018 Starvation: per-requester wait counters for CPU and blt increment each cycle req is high and not granted, saturate at STARVE_MAX, and clear on grant or when req is low.
REQ-019 Starved requester: a counter equal to STARVE_MAX beats vid; if both CPU and blt are starved, round-robin decides between them.
REQ-020 With no eligible request: ram_en = 0, ram_we = 0, cur_owner = 0; ram_addr and ram_di hold their last values.
REQ-021 ram_we SHALL equal the winner's we only while ram_en = 1; ram_di is the winner's di, or 0 for vid.
REQ-022 At most one ack SHALL be high in any cycle; an ack SHALL only follow a grant.

Reset
REQ-023 Asserting rst SHALL immediately clear the following: all acks, ram_en, ram_we, ram_addr, ram_di, cur_owner, wait counters, and in-flight state; RR pointer is set to favour CPU.
REQ-024 An access in flight when rst asserts SHALL produce no ack; the requester re-requests after rst release.
REQ-025 First grant SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-026 Only cpu_req=1, cpu_we=0, addr 0x0123, VRAM holds 0xA5 -> ram_en=1 with addr 0x0123 after E1; cpu_ack pulse E2-E3 with rdata=0xA5; no regrant at E2.
REQ-027 CPU and blt write simultaneously and continuously (ack-renewed) -> grants alternate CPU, blt, CPU, ... one per cycle; ram_en=1 every cycle; each ack one cycle.
REQ-028 vid_req held continuously, cpu_req high -> vid gets a grant every 2 cycles and CPU gets the gap cycles; with vid and CPU alternating eligibility, CPU wait never reaches STARVE_MAX.
REQ-029 Force vid to win continuously by overriding REQ-014 in a bench-only mode with STARVE_MAX=4 and cpu_req held -> CPU granted on the cycle its counter hits 4; counter then 0.
REQ-030 rst pulsed in the cycle after a blt grant -> no blt_ack, all outputs 0; after release, blt re-request granted at next edge with normal REQ-012 timing.
REQ-031 Random three-requester traffic vs. a reference memory model -> every read returns last written data; at most one ack per cycle; ack count equals grant count.
